// File: rtl/morse_encoder.sv
// Morse character keyer: serialises a 1..5 element dot/dash pattern onto key with standard unit timing.
// Optional feature macro: MORSE_ENC_WORD_GAP_EN (word_end=1 stretches the trailing gap to 7 units).
`default_nettype none

module morse_encoder #(
  parameter int TIME_UNIT = 9_999_999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] code,
  input  logic [2:0] len,
  input  logic       word_end,
  output logic       key,
  output logic       busy,
  output logic       done
);

  localparam int            CW     = (TIME_UNIT < 1) ? 1 : $clog2(TIME_UNIT + 1);
  localparam logic [CW-1:0] C_TICK = CW'(TIME_UNIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MARK  = 2'd1,
    S_SPACE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_unit;
  logic [2:0]    r_idx;
  logic [4:0]    r_code;
  logic          r_done;
  logic          w_len_ok;
  logic          w_accept;
  logic          w_tick;
  logic [2:0]    w_mark_units;
  logic [2:0]    w_gap_units;

`ifdef MORSE_ENC_WORD_GAP_EN
  logic r_word_end;
  assign w_gap_units = r_word_end ? 3'd7 : 3'd3;
`else
  logic w_unused_word_end;
  assign w_unused_word_end = word_end;
  assign w_gap_units       = 3'd3;
`endif

  assign w_len_ok     = (len != 3'd0) && (len <= 3'd5);
  assign w_accept     = start && (r_state == S_IDLE) && w_len_ok;
  assign w_tick       = (r_cnt == C_TICK);
  assign w_mark_units = r_code[r_idx] ? 3'd3 : 3'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MARK;
      S_MARK:  if (w_tick && (r_unit == w_mark_units - 3'd1))
                 w_next = (r_idx != 3'd0) ? S_SPACE : S_GAP;
      S_SPACE: if (w_tick) w_next = S_MARK;
      S_GAP:   if (w_tick && (r_unit == w_gap_units - 3'd1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_unit     <= 3'd0;
      r_idx      <= 3'd0;
      r_code     <= 5'd0;
      r_done     <= 1'b0;
`ifdef MORSE_ENC_WORD_GAP_EN
      r_word_end <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == S_GAP) && (w_next == S_IDLE);
      if (w_accept) begin
        r_code     <= code;
        r_idx      <= len - 3'd1;
`ifdef MORSE_ENC_WORD_GAP_EN
        r_word_end <= word_end;
`endif
      end
      // Element index steps only when moving into the inter-element space, so it never wraps.
      if ((r_state == S_MARK) && (w_next == S_SPACE)) begin
        r_idx <= r_idx - 3'd1;
      end
      if (w_accept || (w_next != r_state)) begin
        r_cnt  <= '0;
        r_unit <= 3'd0;
      end else if (r_state != S_IDLE) begin
        if (w_tick) begin
          r_cnt  <= '0;
          r_unit <= r_unit + 3'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign key  = (r_state == S_MARK);
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder at TIME_UNIT=3 (4 cycles per unit).
`default_nettype none

module tb_morse_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] code = 5'd0;
  logic [2:0] len = 3'd0;
  logic       word_end = 1'b0;
  logic       key;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef MORSE_ENC_WORD_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct {
    bit lvl;
    int n;
  } seg_t;

  seg_t exp_q[$];
  int   exp_nseg_q[$];
  int   exp_busy_q[$];

  morse_encoder #(.TIME_UNIT(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .code     (code),
    .len      (len),
    .word_end (word_end),
    .key      (key),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic void push_char(input logic [4:0] c, input int n, input bit we);
    seg_t s;
    int   b = 0;
    int   k = 0;
    for (int i = n - 1; i >= 0; i--) begin
      s.lvl = 1'b1; s.n = c[i] ? 12 : 4; exp_q.push_back(s); b += s.n; k++;
      if (i > 0) begin
        s.lvl = 1'b0; s.n = 4; exp_q.push_back(s); b += 4; k++;
      end
    end
    s.lvl = 1'b0; s.n = (we && GAP_EN) ? 28 : 12; exp_q.push_back(s); b += s.n; k++;
    exp_nseg_q.push_back(k);
    exp_busy_q.push_back(b);
  endfunction

  // Leaves the caller at the negedge just after the accepting edge.
  task automatic send(input logic [4:0] c, input int n, input bit we, input bit push, input bit hold);
    @(negedge clk);
    code = c; len = n[2:0]; word_end = we; start = 1'b1;
    if (push) push_char(c, n, we);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic observe(input string name);
    seg_t runs[$];
    seg_t s;
    seg_t e;
    int   bcnt = 0;
    int   rl = 0;
    bit   cur = 1'b0;
    bit   got_done = 1'b0;
    int   nexp;
    int   bexp;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done === 1'b1) begin got_done = 1'b1; break; end
      if (busy === 1'b1) begin
        bcnt++;
        if (rl > 0 && key !== cur) begin s.lvl = cur; s.n = rl; runs.push_back(s); rl = 0; end
        cur = key; rl++;
      end
      @(negedge clk);
    end
    if (rl > 0) begin s.lvl = cur; s.n = rl; runs.push_back(s); end
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL %s done_timeout: got no done, required done pulse", name);
    end else begin
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b required 0", name, busy); end
    end
    nexp = exp_nseg_q.pop_front();
    bexp = exp_busy_q.pop_front();
    checks++;
    if (bcnt != bexp) begin errors++; $display("FAIL %s busy_len: got %0d required %0d", name, bcnt, bexp); end
    checks++;
    if (runs.size() != nexp) begin
      errors++; $display("FAIL %s seg_count: got %0d required %0d", name, runs.size(), nexp);
    end
    for (int i = 0; i < nexp; i++) begin
      e = exp_q.pop_front();
      if (i < runs.size()) begin
        checks++;
        if (runs[i].lvl !== e.lvl || runs[i].n != e.n) begin
          errors++;
          $display("FAIL %s seg%0d: got key=%0d x%0d required key=%0d x%0d",
                   name, i, runs[i].lvl, runs[i].n, e.lvl, e.n);
        end
      end
    end
    if (got_done) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b required 0", name, done); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({key, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_state: got key/busy/done=%b required 000", {key, busy, done});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_char_a();
    send(5'b00001, 2, 1'b0, 1'b1, 1'b0);
    observe("A");
  endtask

  task automatic test_char_t_word();
    send(5'b00001, 1, 1'b1, 1'b1, 1'b0);
    observe("T_word");
  endtask

  task automatic test_invalid();
    logic [2:0] bad[3] = '{3'd0, 3'd6, 3'd7};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      code = 5'b10101; len = bad[i]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || key !== 1'b0) begin
        errors++; $display("FAIL invalid_len%0d: got busy=%b key=%b required 0 0", bad[i], busy, key);
      end
    end
  endtask

  task automatic test_busy_request();
    send(5'b00001, 2, 1'b0, 1'b1, 1'b0);
    fork
      observe("A_busy_req");
      begin
        repeat (6) @(negedge clk);
        code = 5'b11111; len = 3'd5; word_end = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
  endtask

  task automatic test_back_to_back();
    send(5'b00000, 1, 1'b0, 1'b1, 1'b1);
    observe("E1");
    checks++;
    if (key !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got key=%b busy=%b required 1 1", key, busy);
    end
    start = 1'b0;
    push_char(5'b00000, 1, 1'b0);
    observe("E2");
  endtask

  task automatic test_reset_mid();
    send(5'b00001, 2, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if (key !== 1'b1) begin errors++; $display("FAIL mid_second_mark: got key=%b required 1", key); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({key, busy, done} !== 3'b000) begin
      errors++; $display("FAIL async_abort: got key/busy/done=%b required 000", {key, busy, done});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({key, busy, done} !== 3'b000) begin
        errors++; $display("FAIL post_abort%0d: got key/busy/done=%b required 000", i, {key, busy, done});
      end
    end
    send(5'b00001, 2, 1'b0, 1'b1, 1'b0);
    observe("A_after_reset");
  endtask

  task automatic test_five_dashes();
    send(5'b11111, 5, 1'b0, 1'b1, 1'b0);
    observe("five_dash");
  endtask

  initial begin
    test_reset();
    test_char_a();
    test_char_t_word();
    test_invalid();
    test_busy_request();
    test_back_to_back();
    test_reset_mid();
    test_five_dashes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
